// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared FSM state type and clock/gate constants for the frequency meter
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } fm_state_e;

    localparam int CLK50_HZ   = 50_000_000;
    localparam int GATE_1S    = 50_000_000;
    localparam int GATE_100MS = 5_000_000;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - synchronizes an asynchronous input and emits a one-cycle rise pulse
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    localparam int WARM_CYCLES = SYNC_STAGES + 1;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;
    logic [WARM_W-1:0]      warm_q;
    logic                   warm_done;

    assign warm_done = (warm_q == WARM_W'(WARM_CYCLES));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
            warm_q  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            delay_q <= sync_q[SYNC_STAGES-1];
            if (!warm_done) begin
                warm_q <= warm_q + 1'b1;
            end
        end
    end

    // Until the chain has filled, a high input looks like a fresh edge; mask it.
    assign rise_o = warm_done & sync_q[SYNC_STAGES-1] & ~delay_q;

endmodule

// File: rtl/freq_meter_50mhz.sv
// rtl/freq_meter_50mhz.sv - gated frequency counter: counts SigIn rising edges over a fixed Clk50MHz window
module freq_meter_50mhz
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_1S,
    parameter int GATE_W      = 26,
    parameter int FREQ_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk50MHz,
    input  logic              Rst_n,
    input  logic              SigIn,
    input  logic              Start,
    input  logic              Continuous,
    output logic [FREQ_W-1:0] Freq,
    output logic              Valid,
    output logic              Busy,
    output logic              Overflow
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0] EDGE_MAX  = '1;

    fm_state_e         state_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [FREQ_W-1:0] edge_cnt_q;
    logic [FREQ_W-1:0] edge_cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [FREQ_W-1:0] freq_q;
    logic              valid_q;
    logic              busy_q;
    logic              overflow_q;
    logic              rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_i (Clk50MHz),
        .rst_ni(Rst_n),
        .sig_i (SigIn),
        .rise_o(rise)
    );

    // Includes this cycle's rise so an edge in the last gate cycle reaches Freq.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        if (rise) begin
            if (edge_cnt_q == EDGE_MAX) begin
                ovf_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q    <= GATE;
                        busy_q     <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                    end
                end
                GATE: begin
                    edge_cnt_q <= edge_cnt_d;
                    ovf_q      <= ovf_d;
                    if (gate_cnt_q == GATE_LAST) begin
                        state_q    <= DONE;
                        freq_q     <= edge_cnt_d;
                        overflow_q <= ovf_d;
                        valid_q    <= 1'b1;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // A rise here belongs to the next back-to-back window.
                    gate_cnt_q <= '0;
                    edge_cnt_q <= FREQ_W'(rise);
                    ovf_q      <= 1'b0;
                    if (Continuous) begin
                        state_q <= GATE;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Freq     = freq_q;
    assign Valid    = valid_q;
    assign Busy     = busy_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter_50mhz.sv
// tb/tb_freq_meter_50mhz.sv - scoreboard bench for freq_meter_50mhz with 16-bit and 4-bit count instances
module tb_freq_meter_50mhz;

    localparam int G = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sig   = 1'b0;
    logic start = 1'b0;
    logic cont  = 1'b0;

    logic [15:0] freq_a;
    logic [3:0]  freq_b;
    logic        valid_a, busy_a, ovf_a;
    logic        valid_b, busy_b, ovf_b;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    int   sig_mode  = 0;
    logic sig_level = 1'b0;
    int   sig_per   = 10;
    int   sig_off   = 0;
    int   pulse_at  = 0;

    typedef struct {
        int freq;
        int ovf;
        int at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic prev_va = 1'b0;
    logic prev_vb = 1'b0;

    freq_meter_50mhz #(
        .GATE_CYCLES(G), .GATE_W(7), .FREQ_W(16), .SYNC_STAGES(2)
    ) dut_a (
        .Clk50MHz(clk), .Rst_n(rst_n), .SigIn(sig), .Start(start), .Continuous(cont),
        .Freq(freq_a), .Valid(valid_a), .Busy(busy_a), .Overflow(ovf_a)
    );

    freq_meter_50mhz #(
        .GATE_CYCLES(G), .GATE_W(7), .FREQ_W(4), .SYNC_STAGES(2)
    ) dut_b (
        .Clk50MHz(clk), .Rst_n(rst_n), .SigIn(sig), .Start(start), .Continuous(cont),
        .Freq(freq_b), .Valid(valid_b), .Busy(busy_b), .Overflow(ovf_b)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (valid_a) begin
            chk("a_valid_single", int'(prev_va), 0);
            chk("a_valid_expected", int'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_freq", int'(freq_a), e.freq);
                chk("a_overflow", int'(ovf_a), e.ovf);
                chk("a_valid_cycle", cyc, e.at);
            end
        end
        prev_va = valid_a;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (valid_b) begin
            chk("b_valid_single", int'(prev_vb), 0);
            chk("b_valid_expected", int'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_freq", int'(freq_b), e.freq);
                chk("b_overflow", int'(ovf_b), e.ovf);
                chk("b_valid_cycle", cyc, e.at);
            end
        end
        prev_vb = valid_b;
    end

    // SigIn source: level, free-running square wave rising when cyc==sig_off mod sig_per, or a 5-cycle pulse.
    initial forever begin
        @(posedge clk);
        #1;
        if (sig_mode == 1)
            sig = ((((cyc - sig_off) % sig_per) + sig_per) % sig_per) < (sig_per / 2);
        else if (sig_mode == 2)
            sig = (cyc >= pulse_at) && (cyc < pulse_at + 5);
        else
            sig = sig_level;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic set_sig(input int mode, input logic level, input int per, input int off);
        @(negedge clk);
        sig_mode  = mode;
        sig_level = level;
        sig_per   = per;
        sig_off   = off;
    endtask

    task automatic pulse_start(output int p);
        do tick(1); while (cyc % 10 != 0);
        start = 1'b1;
        p     = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic expect_both(input int fa, input int oa, input int fb, input int ob, input int at);
        exp_t ea;
        exp_t eb;
        ea = '{fa, oa, at};
        eb = '{fb, ob, at};
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout_pending", qa.size() + qb.size(), 0);
        qa.delete();
        qb.delete();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy_a"}, int'(busy_a), 0);
        chk({tag, "_valid_a"}, int'(valid_a), 0);
        chk({tag, "_freq_a"}, int'(freq_a), 0);
        chk({tag, "_ovf_a"}, int'(ovf_a), 0);
        chk({tag, "_busy_b"}, int'(busy_b), 0);
        chk({tag, "_valid_b"}, int'(valid_b), 0);
        chk({tag, "_freq_b"}, int'(freq_b), 0);
        chk({tag, "_ovf_b"}, int'(ovf_b), 0);
    endtask

    initial begin
        int p;

        tick(3);
        chk_zero_outputs("reset");

        // Single window, period 10 -> 10 edges; Busy spans k+1..k+101
        set_sig(1, 1'b0, 10, 3);
        rst_n = 1'b1;
        tick(10);
        pulse_start(p);
        expect_both(10, 0, 10, 0, p + G + 1);
        at_neg(p + 1);
        chk("busy_after_start_a", int'(busy_a), 1);
        chk("busy_after_start_b", int'(busy_b), 1);
        at_neg(p + G + 1);
        chk("busy_in_done_a", int'(busy_a), 1);
        at_neg(p + G + 2);
        chk("busy_cleared_a", int'(busy_a), 0);
        chk("busy_cleared_b", int'(busy_b), 0);
        drain(50);

        // SigIn high through reset release: warm-up must hide the fake edge
        set_sig(0, 1'b1, 10, 0);
        tick(4);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        start = 1'b1;
        p     = cyc;
        tick(1);
        start = 1'b0;
        expect_both(0, 0, 0, 0, p + G + 1);
        drain(150);

        // Period 4 -> 25 edges: saturates the 4-bit instance, then an idle window clears it
        set_sig(1, 1'b0, 4, 1);
        tick(8);
        pulse_start(p);
        expect_both(25, 0, 15, 1, p + G + 1);
        drain(150);
        set_sig(0, 1'b0, 4, 0);
        tick(6);
        pulse_start(p);
        expect_both(0, 0, 0, 0, p + G + 1);
        drain(150);

        // Continuous, period 10, no rise in DONE: three windows of 10, 101 cycles apart
        set_sig(1, 1'b0, 10, 3);
        tick(10);
        cont = 1'b1;
        pulse_start(p);
        expect_both(10, 0, 10, 0, p + G + 1);
        expect_both(10, 0, 10, 0, p + 2 * (G + 1));
        expect_both(10, 0, 10, 0, p + 3 * (G + 1));
        at_neg(p + 250);
        cont = 1'b0;
        drain(400);
        tick(120);

        // Continuous with one rise landing exactly on the first DONE cycle
        set_sig(0, 1'b0, 10, 0);
        tick(6);
        cont = 1'b1;
        pulse_start(p);
        @(negedge clk);
        pulse_at = p + G - 1;
        sig_mode = 2;
        expect_both(0, 0, 0, 0, p + G + 1);
        expect_both(1, 0, 1, 0, p + 2 * (G + 1));
        at_neg(p + 150);
        cont = 1'b0;
        drain(300);
        tick(120);

        // Start re-pulsed mid-window is dropped
        set_sig(1, 1'b0, 10, 3);
        tick(10);
        pulse_start(p);
        expect_both(10, 0, 10, 0, p + G + 1);
        while (cyc < p + 50) tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        drain(150);
        tick(150);

        // Asynchronous reset mid-window discards the window
        pulse_start(p);
        while (cyc < p + 50) tick(1);
        chk("busy_before_reset_a", int'(busy_a), 1);
        chk("freq_before_reset_a", int'(freq_a), 10);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        tick(3);
        rst_n = 1'b1;
        tick(250);
        chk("idle_after_reset_a", int'(busy_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter_50mhz.md
Name: freq_meter_50mhz

Overview:
- Gated frequency counter clocked from the 50 MHz board clock.
- Measures an external or divided clock (e.g. a 1 Hz/2 Hz divided tick) by counting its rising edges over a fixed gate window of Clk50MHz cycles.
- Reports the count with a one-cycle Valid strobe.
- Serves as the measuring end of the team's clock-division chain, for self-check and display.

Parameters:
- GATE_CYCLES, 50_000_000: Clk50MHz cycles per gate window (1 s at 50 MHz).
- GATE_W, 26: width of the gate counter; must hold GATE_CYCLES-1.
- FREQ_W, 16: width of the edge counter and the Freq output.
- SYNC_STAGES, 2: synchronizer flops on SigIn (≥2).

Ports:
- Clk50MHz  in  1  system clock, 50 MHz.
- Rst_n  in  1  asynchronous, active-low reset.
- SigIn  in  1  signal under measurement; asynchronous to Clk50MHz.
- Start  in  1  level sampled each cycle; starts one measurement when the block is idle.
- Continuous  in  1  when 1, windows restart back-to-back.
- Freq  out  FREQ_W  rising edges counted in the last completed window.
- Valid  out  1  one-cycle pulse when Freq/Overflow update.
- Busy  out  1  high while a window is in progress.
- Overflow  out  1  last window's count exceeded 2^FREQ_W-1.

Interface rule: one clock, Clk50MHz. Rst_n is asynchronous and active-low.

Behaviour:
Reset:
- Rst_n low clears asynchronously: Freq=0, Valid=0, Busy=0, Overflow=0, FSM=IDLE, all counters=0, synchronizer flops=0.
- Reset mid-window discards that window. No Valid is produced for it.

Edge detection:
- SigIn passes through SYNC_STAGES flops, then a delay flop.
- rise = sync_out & ~delayed.
- rise is forced 0 for the first SYNC_STAGES+1 cycles after Rst_n deasserts (warm-up). This prevents a false edge when SigIn is high at reset.
- SigIn high and low phases must each last ≥2 Clk50MHz cycles. Shorter pulses may be lost.

FSM states: IDLE, GATE, DONE.
- IDLE:
  - Start=1 → GATE next cycle; gate_cnt=0, edge_cnt=0.
  - Busy=0.
- GATE:
  - gate_cnt increments each cycle.
  - edge_cnt increments on each rise.
  - When gate_cnt==GATE_CYCLES-1 → DONE. The window is exactly GATE_CYCLES cycles.
  - Busy=1.
- DONE (exactly one cycle):
  - Freq <= edge_cnt; Overflow <= ovf flag; Valid=1; Busy=1.
  - If Continuous=1 → GATE with gate_cnt=0 and edge_cnt = rise?1:0. A rise during DONE is therefore credited to the next window, so no edges are lost.
  - Otherwise → IDLE.

Latency: Start sampled high at cycle k (IDLE) → Busy high from k+1 → Valid high at cycle k+1+GATE_CYCLES.

Counter width rules:
- edge_cnt saturates at 2^FREQ_W-1.
- A rise arriving while edge_cnt is saturated sets the ovf flag. ovf clears at window start.

Other rules:
- Start while Busy=1 is ignored; it is not queued.
- Continuous deasserted mid-window: the current window completes and reports, then the FSM goes to IDLE.
- Freq and Overflow hold their values between Valid pulses.
- Valid is never high for more than 1 consecutive cycle.

Decomposition:
- Package freq_meter_pkg:
  - FSM state enum (IDLE/GATE/DONE).
  - Constants CLK50_HZ=50_000_000, GATE_1S=50_000_000, GATE_100MS=5_000_000.
- Sub-module sync_edge_detect:
  - SYNC_STAGES synchronizer, delay flop, warm-up suppression counter.
  - Outputs the rise pulse.
- The FSM, counters and output registers stay in the top module.

Test Plan (simulated with GATE_CYCLES=100 unless noted):
1. Reset, then SigIn period 10 cycles (5H/5L), Start pulse at cycle k → Busy=1 at k+1, Valid at k+101, Freq=10, Overflow=0, Busy=0 at k+102.
2. SigIn held 1 through reset release and beyond, Start in the first cycle after reset → Freq=0. No false edge from the warm-up window.
3. FREQ_W=4, SigIn period 4 (2H/2L) → 25 edges in the window → Freq=15, Overflow=1. A following window with SigIn idle → Freq=0, Overflow=0.
4. Continuous=1, SigIn period 10:
   - Valid pulses every 101 cycles, each with Freq=10.
   - Align one rise to the DONE cycle → that rise is counted in the next window, not lost.
5. Start re-pulsed at k+50 while Busy → ignored, exactly one Valid.
6. Rst_n low at k+50 mid-window → Busy, Freq, Valid and Overflow all 0 immediately (asynchronous), and no Valid afterwards without a new Start.
